mult_taint_radix: RTL and testbench

- Parametrised successor to the shift-add taint-tracking multiplier. Processes DIGIT multiplier bits per cycle and can optionally terminate early once the remaining multiplier bits are zero.
- Tracks data taint (bit-level, carry-smeared) and control taint (FSM/timing). Provides a state-taint kill input that clears the control taint.
- Sits in the same arithmetic/IFT datapath tier as the existing multiplier. Drop-in for wider operand and variable-latency studies.

---
 rtl/mult_taint_radix.sv | 171 +++++++++++++++++
 tb/tb_mult_taint_radix.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_taint_radix.sv
// Radix-2^DIGIT iterative multiplier with bit-level data taint and FSM control taint.
// Optionally terminates early once the remaining multiplier digits are all zero.
module mult_taint_radix #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DIGIT      = 2,
  parameter int unsigned EARLY_TERM = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               start_t,
  input  logic               state_t_kill,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplier_t,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplicand_t,
  output logic               busy,
  output logic               busy_t,
  output logic [2*WIDTH-1:0] product,
  output logic [2*WIDTH-1:0] product_t,
  output logic               productDone,
  output logic               productDone_t
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = $clog2(PW) + 1;

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("mult_taint_radix: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Set every bit at and above the lowest set bit.
  function automatic logic [PW-1:0] smear_up(input logic [PW-1:0] x);
    logic [PW-1:0] r;
    logic          seen;
    seen = 1'b0;
    for (int j = 0; j < int'(PW); j++) begin
      seen = seen | x[j];
      r[j] = seen;
    end
    return r;
  endfunction

  state_e            state_d, state_q;
  logic [WIDTH-1:0]  mreg_d, mreg_q, mreg_t_d, mreg_t_q;
  logic [WIDTH-1:0]  mcand_d, mcand_q, mcand_t_d, mcand_t_q;
  logic [PW:0]       acc_d, acc_q;
  logic [PW-1:0]     acc_t_d, acc_t_q;
  logic [IW-1:0]     idx_d, idx_q;
  logic              ctrl_t_d, ctrl_t_q;
  logic [PW-1:0]     product_d, product_q, product_t_d, product_t_q;
  logic              done_d, done_q, done_t_d, done_t_q;

  logic [SW-1:0]     shamt, hi_shamt;
  logic [DIGIT-1:0]  digit, digit_t;
  logic [PW-1:0]     pp, pp_t;
  logic              upper_zero, upper_t, last;

  always_comb begin
    shamt      = SW'(idx_q) * SW'(DIGIT);
    hi_shamt   = shamt + SW'(DIGIT);
    digit      = DIGIT'(mreg_q >> shamt);
    digit_t    = DIGIT'(mreg_t_q >> shamt);
    pp         = (PW'(mcand_q) * PW'(digit)) << shamt;
    if (|digit_t) begin
      pp_t = smear_up(PW'(1) << shamt);
    end else if (digit == '0) begin
      pp_t = '0;
    end else begin
      pp_t = smear_up(PW'(mcand_t_q) << shamt);
    end
    upper_zero = ((mreg_q >> hi_shamt) == '0);
    upper_t    = |(mreg_t_q >> hi_shamt);
    last       = (idx_q == IW'(N - 1)) || ((EARLY_TERM != 0) && upper_zero);
  end

  always_comb begin
    state_d     = state_q;
    mreg_d      = mreg_q;
    mreg_t_d    = mreg_t_q;
    mcand_d     = mcand_q;
    mcand_t_d   = mcand_t_q;
    acc_d       = acc_q;
    acc_t_d     = acc_t_q;
    idx_d       = idx_q;
    ctrl_t_d    = ctrl_t_q;
    product_d   = product_q;
    product_t_d = product_t_q;
    done_d      = 1'b0;
    done_t_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          mreg_d    = multiplier;
          mreg_t_d  = multiplier_t;
          mcand_d   = multiplicand;
          mcand_t_d = multiplicand_t;
          acc_d     = '0;
          acc_t_d   = '0;
          idx_d     = '0;
          ctrl_t_d  = start_t;
          state_d   = StRun;
        end
      end
      StRun: begin
        acc_d   = acc_q + {1'b0, pp};
        acc_t_d = smear_up(acc_t_q | pp_t);
        // With early termination the latency leaks the upper multiplier bits.
        if (EARLY_TERM != 0) ctrl_t_d = ctrl_t_q | upper_t;
        if (last) state_d = StDone;
        else      idx_d   = idx_q + IW'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_t_kill) ctrl_t_d = 1'b0;

    if ((state_q == StRun) && last) begin
      product_d   = acc_d[PW-1:0];
      product_t_d = ctrl_t_d ? '1 : acc_t_d;
      done_d      = 1'b1;
      done_t_d    = ctrl_t_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mreg_q      <= '0;
      mreg_t_q    <= '0;
      mcand_q     <= '0;
      mcand_t_q   <= '0;
      acc_q       <= '0;
      acc_t_q     <= '0;
      idx_q       <= '0;
      ctrl_t_q    <= 1'b0;
      product_q   <= '0;
      product_t_q <= '0;
      done_q      <= 1'b0;
      done_t_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mreg_q      <= mreg_d;
      mreg_t_q    <= mreg_t_d;
      mcand_q     <= mcand_d;
      mcand_t_q   <= mcand_t_d;
      acc_q       <= acc_d;
      acc_t_q     <= acc_t_d;
      idx_q       <= idx_d;
      ctrl_t_q    <= ctrl_t_d;
      product_q   <= product_d;
      product_t_q <= product_t_d;
      done_q      <= done_d;
      done_t_q    <= done_t_d;
    end
  end

  assign busy          = (state_q == StRun);
  assign busy_t        = busy & ctrl_t_q;
  assign product       = product_q;
  assign product_t     = product_t_q;
  assign productDone   = done_q;
  assign productDone_t = done_t_q;

endmodule

// File: tb/tb_mult_taint_radix.sv
// Directed bench for mult_taint_radix: one fixed-latency and one early-terminating instance
// share the same stimulus; each vector is checked on the instance it targets.
module tb_mult_taint_radix;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start_t, state_t_kill;
  logic [7:0]  multiplier, multiplier_t, multiplicand, multiplicand_t;

  logic        busy0, busy_t0, done0, done_t0;
  logic [15:0] product0, product_t0;
  logic        busy1, busy_t1, done1, done_t1;
  logic [15:0] product1, product_t1;

  int          n_checks = 0;
  int          n_fail   = 0;

  logic [15:0] r_p, r_pt;
  logic        r_dt;
  int          r_cycles;
  logic [7:0]  r_btv;

  always #5 clk = ~clk;

  mult_taint_radix #(.WIDTH(8), .DIGIT(2), .EARLY_TERM(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .start_t(start_t), .state_t_kill(state_t_kill),
    .multiplier(multiplier), .multiplier_t(multiplier_t),
    .multiplicand(multiplicand), .multiplicand_t(multiplicand_t),
    .busy(busy0), .busy_t(busy_t0), .product(product0), .product_t(product_t0),
    .productDone(done0), .productDone_t(done_t0)
  );

  mult_taint_radix #(.WIDTH(8), .DIGIT(2), .EARLY_TERM(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .start_t(start_t), .state_t_kill(state_t_kill),
    .multiplier(multiplier), .multiplier_t(multiplier_t),
    .multiplicand(multiplicand), .multiplicand_t(multiplicand_t),
    .busy(busy1), .busy_t(busy_t1), .product(product1), .product_t(product_t1),
    .productDone(done1), .productDone_t(done_t1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one operation and follow the selected instance until productDone (bounded).
  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] at,
                        input logic [7:0] b, input logic [7:0] bt, input logic st,
                        input int kill_cyc, input bit poke_start);
    logic sb, sbt, sd, sdt;
    logic [15:0] sp, spt;
    bit done;
    @(negedge clk);
    multiplier = a; multiplier_t = at; multiplicand = b; multiplicand_t = bt;
    start = 1'b1; start_t = st;
    @(negedge clk);
    start = 1'b0; start_t = 1'b0;
    r_cycles = 0; r_btv = '0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      sb  = sel != 0 ? busy1      : busy0;
      sbt = sel != 0 ? busy_t1    : busy_t0;
      sd  = sel != 0 ? done1      : done0;
      sdt = sel != 0 ? done_t1    : done_t0;
      sp  = sel != 0 ? product1   : product0;
      spt = sel != 0 ? product_t1 : product_t0;
      if (sd) begin
        r_p = sp; r_pt = spt; r_dt = sdt; done = 1'b1;
      end else if (sb) begin
        r_cycles++;
        if (r_cycles < 8) r_btv[r_cycles] = sbt;
      end
      state_t_kill = (kill_cyc != 0) && (r_cycles == kill_cyc) && !done;
      if (poke_start) begin
        start      = (r_cycles == 2) && !done;
        multiplier = ((r_cycles == 2) && !done) ? 8'hFF : a;
      end
      if (!done) @(negedge clk);
    end
    state_t_kill = 1'b0;
    start        = 1'b0;
    check_eq("op_completes", 32'(done), 32'd1);
  endtask

  task automatic gap();
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; start_t = 1'b0; state_t_kill = 1'b0;
    multiplier = '0; multiplier_t = '0; multiplicand = '0; multiplicand_t = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy",      32'(busy0),      32'd0);
    check_eq("rst_product",   32'(product0),   32'd0);
    check_eq("rst_product_t", 32'(product_t0), 32'd0);
    check_eq("rst_done",      32'(done0),      32'd0);

    // Fixed latency, clean operands: 11*13.
    run_op(0, 8'd11, 8'h00, 8'd13, 8'h00, 1'b0, 0, 1'b0);
    check_eq("t1_cycles", 32'(r_cycles), 32'd4);
    check_eq("t1_p",      32'(r_p),      32'h008F);
    check_eq("t1_pt",     32'(r_pt),     32'h0000);
    check_eq("t1_dt",     32'(r_dt),     32'd0);
    gap();

    run_op(0, 8'd11, 8'h00, 8'd13, 8'h01, 1'b0, 0, 1'b0);
    check_eq("t2_p",  32'(r_p),  32'h008F);
    check_eq("t2_pt", 32'(r_pt), 32'hFFFF);
    check_eq("t2_dt", 32'(r_dt), 32'd0);
    gap();

    run_op(0, 8'h01, 8'h00, 8'h05, 8'h10, 1'b0, 0, 1'b0);
    check_eq("t3_p",  32'(r_p),  32'h0005);
    check_eq("t3_pt", 32'(r_pt), 32'hFFF0);
    gap();

    // Early termination: tainted upper multiplier bit leaks through latency.
    run_op(1, 8'h03, 8'h80, 8'h07, 8'h00, 1'b0, 0, 1'b0);
    check_eq("t4_cycles", 32'(r_cycles), 32'd1);
    check_eq("t4_p",      32'(r_p),      32'h0015);
    check_eq("t4_dt",     32'(r_dt),     32'd1);
    check_eq("t4_pt",     32'(r_pt),     32'hFFFF);
    gap();

    run_op(1, 8'h03, 8'h00, 8'h07, 8'h00, 1'b0, 0, 1'b0);
    check_eq("t5_cycles", 32'(r_cycles), 32'd1);
    check_eq("t5_p",      32'(r_p),      32'h0015);
    check_eq("t5_pt",     32'(r_pt),     32'h0000);
    check_eq("t5_dt",     32'(r_dt),     32'd0);
    gap();

    run_op(1, 8'd11, 8'h00, 8'd13, 8'h00, 1'b0, 0, 1'b0);
    check_eq("t6_cycles", 32'(r_cycles), 32'd2);
    check_eq("t6_p",      32'(r_p),      32'h008F);
    gap();

    run_op(1, 8'h00, 8'h00, 8'h5A, 8'h00, 1'b0, 0, 1'b0);
    check_eq("t7_cycles", 32'(r_cycles), 32'd1);
    check_eq("t7_p",      32'(r_p),      32'h0000);
    gap();

    // Control taint from start_t, killed in the 2nd RUN cycle.
    run_op(0, 8'd11, 8'h00, 8'd13, 8'h00, 1'b1, 2, 1'b0);
    check_eq("t8_bt_c1", 32'(r_btv[1]), 32'd1);
    check_eq("t8_bt_c2", 32'(r_btv[2]), 32'd1);
    check_eq("t8_bt_c3", 32'(r_btv[3]), 32'd0);
    check_eq("t8_p",     32'(r_p),      32'h008F);
    check_eq("t8_pt",    32'(r_pt),     32'h0000);
    check_eq("t8_dt",    32'(r_dt),     32'd0);
    gap();

    run_op(0, 8'd11, 8'h00, 8'd13, 8'h00, 1'b1, 0, 1'b0);
    check_eq("t9_bt_c4", 32'(r_btv[4]), 32'd1);
    check_eq("t9_pt",    32'(r_pt),     32'hFFFF);
    check_eq("t9_dt",    32'(r_dt),     32'd1);
    gap();

    // Asynchronous reset in the 3rd RUN cycle.
    @(negedge clk);
    multiplier = 8'd11; multiplier_t = '0; multiplicand = 8'd13; multiplicand_t = '0;
    start = 1'b1; start_t = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("r_busy_before", 32'(busy0), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("r_busy",      32'(busy0),      32'd0);
    check_eq("r_busy_t",    32'(busy_t0),    32'd0);
    check_eq("r_product",   32'(product0),   32'd0);
    check_eq("r_product_t", 32'(product_t0), 32'd0);
    check_eq("r_done",      32'(done0),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done0) pulses++;
    end
    check_eq("r_no_done", 32'(pulses), 32'd0);

    // Fresh operation after reset, with a start pulse while busy.
    run_op(0, 8'd11, 8'h00, 8'd13, 8'h00, 1'b0, 0, 1'b1);
    check_eq("r2_cycles", 32'(r_cycles), 32'd4);
    check_eq("r2_p",      32'(r_p),      32'h008F);
    check_eq("r2_pt",     32'(r_pt),     32'h0000);
    @(negedge clk);
    check_eq("r2_idle", 32'(busy0), 32'd0);
    gap();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
